// File: rtl/mem_req_engine.sv
// Request sequencer in front of the scratch memory: streams MWr payload into MEM
// one DW per cycle and returns MRd contents as a valid/ready completion stream.
module mem_req_engine #(
  parameter int DEPTH      = 32,
  parameter int DATA_WIDTH = 32,
  parameter int LEN_WIDTH  = 6,
  localparam int ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_is_write,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [LEN_WIDTH-1:0]  req_len,
  output logic                  req_err,
  input  logic                  wdata_valid,
  output logic                  wdata_ready,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic                  cpl_valid,
  input  logic                  cpl_ready,
  output logic [DATA_WIDTH-1:0] cpl_data,
  output logic                  cpl_last,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic [DATA_WIDTH-1:0] mem_data_in,
  output logic                  mem_wr_en,
  input  logic [DATA_WIDTH-1:0] mem_data_out,
  output logic                  busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    READ  = 2'd2
  } state_t;

  state_t                state_reg, state_next;
  logic [ADDR_WIDTH-1:0] cur_addr_reg, cur_addr_next;
  logic [LEN_WIDTH-1:0]  remaining_reg, remaining_next;
  logic                  req_err_reg, req_err_next;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg     <= IDLE;
      cur_addr_reg  <= '0;
      remaining_reg <= '0;
      req_err_reg   <= 1'b0;
    end else begin
      state_reg     <= state_next;
      cur_addr_reg  <= cur_addr_next;
      remaining_reg <= remaining_next;
      req_err_reg   <= req_err_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    cur_addr_next  = cur_addr_reg;
    remaining_next = remaining_reg;
    req_err_next   = 1'b0;
    req_ready      = 1'b0;
    wdata_ready    = 1'b0;
    cpl_valid      = 1'b0;
    cpl_last       = 1'b0;
    mem_wr_en      = 1'b0;

    case (state_reg)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          if (req_len != '0) begin
            cur_addr_next  = req_addr;
            remaining_next = req_len;
            state_next     = req_is_write ? WRITE : READ;
          end else begin
            req_err_next = 1'b1;
          end
        end
      end
      WRITE: begin
        wdata_ready = 1'b1;
        mem_wr_en   = wdata_valid;
        if (wdata_valid) begin
          cur_addr_next  = cur_addr_reg + ADDR_WIDTH'(1);
          remaining_next = remaining_reg - LEN_WIDTH'(1);
          if (remaining_reg == LEN_WIDTH'(1)) state_next = IDLE;
        end
      end
      READ: begin
        cpl_valid = 1'b1;
        cpl_last  = (remaining_reg == LEN_WIDTH'(1));
        if (cpl_ready) begin
          cur_addr_next  = cur_addr_reg + ADDR_WIDTH'(1);
          remaining_next = remaining_reg - LEN_WIDTH'(1);
          if (remaining_reg == LEN_WIDTH'(1)) state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase

    // Handshake outputs are squelched while reset is held so a burst aborts at once.
    if (!rst) begin
      req_ready   = 1'b0;
      wdata_ready = 1'b0;
      cpl_valid   = 1'b0;
      cpl_last    = 1'b0;
      mem_wr_en   = 1'b0;
    end
  end

  assign req_err     = req_err_reg;
  assign mem_address = cur_addr_reg;
  assign mem_data_in = wdata;
  assign cpl_data    = mem_data_out;
  assign busy        = rst && (state_reg != IDLE);

endmodule

// File: tb/tb_mem_req_engine.sv
// Randomized self-checking bench for mem_req_engine with a behavioural memory
// image as reference; reads are checked beat by beat against that image.
module tb_mem_req_engine;

  localparam int DEPTH = 32;
  localparam int DW    = 32;
  localparam int LW    = 6;
  localparam int AW    = $clog2(DEPTH);

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic          req_is_write = 1'b0;
  logic [AW-1:0] req_addr = '0;
  logic [LW-1:0] req_len = '0;
  logic          req_err;
  logic          wdata_valid = 1'b0;
  logic          wdata_ready;
  logic [DW-1:0] wdata = '0;
  logic          cpl_valid;
  logic          cpl_ready = 1'b0;
  logic [DW-1:0] cpl_data;
  logic          cpl_last;
  logic [AW-1:0] mem_address;
  logic [DW-1:0] mem_data_in;
  logic          mem_wr_en;
  logic [DW-1:0] mem_data_out;
  logic          busy;

  mem_req_engine #(.DEPTH(DEPTH), .DATA_WIDTH(DW), .LEN_WIDTH(LW)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_is_write(req_is_write),
    .req_addr(req_addr), .req_len(req_len), .req_err(req_err),
    .wdata_valid(wdata_valid), .wdata_ready(wdata_ready), .wdata(wdata),
    .cpl_valid(cpl_valid), .cpl_ready(cpl_ready), .cpl_data(cpl_data), .cpl_last(cpl_last),
    .mem_address(mem_address), .mem_data_in(mem_data_in), .mem_wr_en(mem_wr_en),
    .mem_data_out(mem_data_out), .busy(busy)
  );

  always #5 clk = ~clk;

  // The scratch memory the engine drives.
  logic          mem_clear = 1'b1;
  logic [DW-1:0] mem [DEPTH];
  assign mem_data_out = mem[mem_address];
  always @(posedge clk) begin
    if (mem_clear) begin
      for (int k = 0; k < DEPTH; k++) mem[k] <= '0;
    end else if (mem_wr_en) begin
      mem[mem_address] <= mem_data_in;
    end
  end

  // Reference image: what memory must contain according to accepted writes.
  logic [DW-1:0] ref_mem [DEPTH];
  logic [DW-1:0] wq [$];
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Issue MWr; data is taken from wq. Optional random gaps in wdata_valid.
  task automatic do_write(input int addr, input int len, input bit gaps);
    req_valid = 1'b1; req_is_write = 1'b1; req_addr = AW'(addr); req_len = LW'(len);
    #1 check("wr_req_ready", DW'(req_ready), 1);
    next_cycle();
    req_valid = 1'b0;
    for (int i = 0; i < len; i++) begin
      while (gaps && ($urandom_range(0, 2) == 0)) begin
        wdata_valid = 1'b0;
        #1 check("wr_gap_no_write", DW'(mem_wr_en), 0);
        check("wr_gap_busy", DW'(busy), 1);
        next_cycle();
      end
      wdata_valid = 1'b1;
      wdata = wq[i];
      #1 check("wr_en", DW'(mem_wr_en), 1);
      check("wr_addr", DW'(mem_address), DW'((addr + i) % DEPTH));
      check("wr_ready", DW'(wdata_ready), 1);
      ref_mem[(addr + i) % DEPTH] = wq[i];
      next_cycle();
    end
    wdata_valid = 1'b0;
    #1 check("wr_done_idle", DW'(busy), 0);
    check("wr_done_req_ready", DW'(req_ready), 1);
    check("wr_done_no_write", DW'(mem_wr_en), 0);
  endtask

  // Issue MRd; cpl_ready held low for stall0 cycles on beat 0, random afterwards if rnd.
  task automatic do_read(input int addr, input int len, input int stall0, input bit rnd);
    int i = 0;
    int cyc = 0;
    int st = stall0;
    req_valid = 1'b1; req_is_write = 1'b0; req_addr = AW'(addr); req_len = LW'(len);
    #1 check("rd_req_ready", DW'(req_ready), 1);
    next_cycle();
    req_valid = 1'b0;
    while (i < len && cyc < 200) begin
      if (st > 0) begin cpl_ready = 1'b0; st--; end
      else cpl_ready = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
      #1 check("rd_valid", DW'(cpl_valid), 1);
      check("rd_data", cpl_data, ref_mem[(addr + i) % DEPTH]);
      check("rd_addr", DW'(mem_address), DW'((addr + i) % DEPTH));
      check("rd_last", DW'(cpl_last), DW'(i == len - 1));
      check("rd_no_write", DW'(mem_wr_en), 0);
      if (cpl_ready) i++;
      cyc++;
      next_cycle();
    end
    check("rd_beats_done", DW'(i), DW'(len));
    cpl_ready = 1'b0;
    #1 check("rd_done_idle", DW'(busy), 0);
    check("rd_done_valid", DW'(cpl_valid), 0);
    check("rd_done_req_ready", DW'(req_ready), 1);
  endtask

  initial begin
    for (int k = 0; k < DEPTH; k++) ref_mem[k] = '0;

    // Reset held for 3 cycles: all handshake outputs low.
    for (int c = 0; c < 3; c++) begin
      next_cycle();
      check("rst_req_ready", DW'(req_ready), 0);
      check("rst_wdata_ready", DW'(wdata_ready), 0);
      check("rst_cpl_valid", DW'(cpl_valid), 0);
      check("rst_wr_en", DW'(mem_wr_en), 0);
      check("rst_busy", DW'(busy), 0);
      check("rst_req_err", DW'(req_err), 0);
    end
    mem_clear = 1'b0;
    rst = 1'b1;
    #1 check("rel_req_ready", DW'(req_ready), 1);
    check("rel_addr", DW'(mem_address), 0);
    next_cycle();

    // Directed burst and readback.
    wq = '{32'hA0, 32'hA1, 32'hA2};
    do_write(4, 3, 1'b0);
    next_cycle();
    do_read(4, 3, 0, 1'b0);

    // Wrap-around.
    wq = '{32'hC0, 32'hC1, 32'hC2, 32'hC3};
    do_write(30, 4, 1'b0);
    do_read(30, 4, 0, 1'b0);

    // Read backpressure on beat 0.
    do_read(4, 2, 3, 1'b0);

    // Write with payload gaps.
    wq = '{32'hD0, 32'hD1, 32'hD2, 32'hD3, 32'hD4};
    do_write(12, 5, 1'b1);
    do_read(12, 5, 0, 1'b1);

    // Zero-length request.
    req_valid = 1'b1; req_is_write = 1'b1; req_addr = AW'(7); req_len = '0;
    #1 check("zl_req_ready", DW'(req_ready), 1);
    next_cycle();
    req_valid = 1'b0;
    check("zl_err_pulse", DW'(req_err), 1);
    check("zl_busy", DW'(busy), 0);
    check("zl_no_write", DW'(mem_wr_en), 0);
    next_cycle();
    check("zl_err_clear", DW'(req_err), 0);
    check("zl_busy2", DW'(busy), 0);

    // Reset after two beats of a 4-beat write.
    req_valid = 1'b1; req_is_write = 1'b1; req_addr = AW'(20); req_len = LW'(4);
    next_cycle();
    req_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      wdata_valid = 1'b1;
      wdata = 32'hB0 + DW'(i);
      ref_mem[20 + i] = wdata;
      next_cycle();
    end
    wdata = 32'hB2;
    rst = 1'b0;
    #1 check("abort_no_write", DW'(mem_wr_en), 0);
    check("abort_busy", DW'(busy), 0);
    next_cycle();
    rst = 1'b1;
    wdata_valid = 1'b0;
    #1 check("abort_idle", DW'(busy), 0);
    check("abort_addr", DW'(mem_address), 0);
    do_read(20, 4, 0, 1'b0);

    // Randomized traffic.
    for (int t = 0; t < 25; t++) begin
      int a = $urandom_range(0, DEPTH - 1);
      int l = $urandom_range(1, 9);
      if ($urandom_range(0, 1) == 1) begin
        wq.delete();
        for (int k = 0; k < l; k++) wq.push_back($urandom);
        do_write(a, l, 1'b1);
      end else begin
        do_read(a, l, $urandom_range(0, 2), 1'b1);
      end
      if ($urandom_range(0, 1) == 1) next_cycle();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
